keypad_digit_entry: RTL and testbench

//  Consumes the keypad priority encoder output (D[3:0], valid) and builds the cook-time entry.

---
 rtl/keypad_digit_entry_pkg.sv | 19 +
 rtl/keypad_digit_entry_debouncer.sv | 91 +++++++++
 rtl/keypad_digit_entry.sv | 64 ++++++
 tb/tb_keypad_digit_entry.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_digit_entry_pkg.sv
// Shared definitions for the microwave keypad digit-entry block:
// BCD limits, buffer depth and the debouncer state encoding.
package keypad_digit_entry_pkg;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    function automatic logic isDigit(input logic [3:0] code);
        return code <= BCD_MAX;
    endfunction

endpackage

// File: rtl/keypad_digit_entry_debouncer.sv
// Press/release debouncer for the encoded keypad: emits one accept pulse per
// stable press and stays busy until the key has been stably released.
module keypad_digit_entry_debouncer
    import keypad_digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] D,
    input  logic       valid,
    output logic [3:0] key_q,
    output logic       accept_pulse,
    output logic       busy
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    state_t        r_state;
    state_t        w_stateNext;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cntNext;
    logic [3:0]    r_keyQ;
    logic [3:0]    w_keyQNext;
    logic          w_accept;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_keyQ  <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_keyQ  <= w_keyQNext;
        end
    end

    // A code change or encoder glitch restarts the press window rather than aborting it.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_keyQNext  = r_keyQ;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid && isDigit(D)) begin
                    w_keyQNext  = D;
                    w_cntNext   = CNT_ONE;
                    w_stateNext = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!valid) begin
                    w_stateNext = IDLE;
                end else if ((D != r_keyQ) || !isDigit(D)) begin
                    w_keyQNext = D;
                    w_cntNext  = CNT_ONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_accept    = 1'b1;
                    w_stateNext = HELD;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!valid) begin
                    w_cntNext   = CNT_ONE;
                    w_stateNext = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (valid) begin
                    w_stateNext = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = IDLE;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign key_q        = r_keyQ;
    assign accept_pulse = w_accept;
    assign busy         = (r_state != IDLE);

endmodule

// File: rtl/keypad_digit_entry.sv
// Microwave cook-time entry: debounced digits shift right-to-left into a
// 4-digit BCD MM:SS buffer, gated by enable and emptied by clear.
module keypad_digit_entry
    import keypad_digit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  D,
    input  logic        valid,
    input  logic        enable,
    input  logic        clear,
    output logic [15:0] digits,
    output logic        digit_stb,
    output logic [2:0]  digit_count,
    output logic        busy
);

    logic [3:0]  w_keyQ;
    logic        w_accept;
    logic [15:0] r_digits;
    logic        r_digitStb;
    logic [2:0]  r_digitCount;

    keypad_digit_entry_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk         (clk),
        .rst_n       (rst_n),
        .D           (D),
        .valid       (valid),
        .key_q       (w_keyQ),
        .accept_pulse(w_accept),
        .busy        (busy)
    );

    // Clear outranks a simultaneous acceptance; a press taken while disabled is simply lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digits     <= 16'h0000;
            r_digitStb   <= 1'b0;
            r_digitCount <= 3'd0;
        end else if (clear) begin
            r_digits     <= 16'h0000;
            r_digitStb   <= 1'b0;
            r_digitCount <= 3'd0;
        end else begin
            r_digitStb <= 1'b0;
            if (w_accept && enable) begin
                r_digits   <= {r_digits[11:0], w_keyQ};
                r_digitStb <= 1'b1;
                if (r_digitCount != 3'(NUM_DIGITS)) begin
                    r_digitCount <= r_digitCount + 3'd1;
                end
            end
        end
    end

    assign digits      = r_digits;
    assign digit_stb   = r_digitStb;
    assign digit_count = r_digitCount;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry (DEBOUNCE_CYCLES=4); expected strobed
// buffer values are queued by the stimulus and checked by a strobe monitor.
module tb_keypad_digit_entry;

    typedef struct packed {
        logic [15:0] digits;
        logic [2:0]  count;
    } sbEntry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  D;
    logic        valid;
    logic        enable;
    logic        clear;
    logic [15:0] digits;
    logic        digit_stb;
    logic [2:0]  digit_count;
    logic        busy;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          strobeCount = 0;
    sbEntry_t    sb[$];
    sbEntry_t    expEntry;
    int          strobesBefore;

    keypad_digit_entry #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .D          (D),
        .valid      (valid),
        .enable     (enable),
        .clear      (clear),
        .digits     (digits),
        .digit_stb  (digit_stb),
        .digit_count(digit_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
        end
    endtask

    // Drive valid/D, then let the given number of rising edges pass; returns #1 after the last edge.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input int cycles);
        valid = v;
        D     = d;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && digit_stb === 1'b1) begin
            strobeCount++;
            testsRun++;
            if (sb.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected strobe: got digits=%h count=%0d, wanted no strobe", digits, digit_count);
            end else begin
                expEntry = sb.pop_front();
                if (digits !== expEntry.digits || digit_count !== expEntry.count) begin
                    testsFailed++;
                    $display("[TB] FAIL strobe value: got digits=%h count=%0d, wanted digits=%h count=%0d",
                             digits, digit_count, expEntry.digits, expEntry.count);
                end
            end
        end
    end

    initial begin
        // Test 1: reset held with a key already pressed
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0; valid = 1'b1; D = 4'd5;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("reset digits", 32'(digits), 32'h0000);
        checkOutput("reset stb", 32'(digit_stb), 32'd0);
        checkOutput("reset count", 32'(digit_count), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        sb.push_back('{16'h0005, 3'd1});
        applyStimulus(1'b1, 4'd5, 3);
        checkOutput("t1 no early stb", 32'(digit_stb), 32'd0);
        checkOutput("t1 busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 4'd5, 1);
        checkOutput("t1 stb latency", 32'(digit_stb), 32'd1);
        checkOutput("t1 digits", 32'(digits), 32'h0005);
        applyStimulus(1'b0, 4'd5, 10);
        checkOutput("t1 idle busy", 32'(busy), 32'd0);

        clear = 1'b1;
        applyStimulus(1'b0, 4'd0, 1);
        clear = 1'b0;
        checkOutput("clear digits", 32'(digits), 32'h0000);
        checkOutput("clear count", 32'(digit_count), 32'd0);

        // Test 2: clean presses 1..5, count saturates at 4
        strobesBefore = strobeCount;
        sb.push_back('{16'h0001, 3'd1});
        sb.push_back('{16'h0012, 3'd2});
        sb.push_back('{16'h0123, 3'd3});
        sb.push_back('{16'h1234, 3'd4});
        sb.push_back('{16'h2345, 3'd4});
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 4'(k), 10);
            applyStimulus(1'b0, 4'(k), 10);
        end
        checkOutput("t2 digits", 32'(digits), 32'h2345);
        checkOutput("t2 count", 32'(digit_count), 32'd4);
        checkOutput("t2 strobes", 32'(strobeCount - strobesBefore), 32'd5);

        // Test 3: press and release bounce on key 7
        sb.push_back('{16'h3457, 3'd4});
        applyStimulus(1'b1, 4'd7, 1);
        applyStimulus(1'b0, 4'd7, 1);
        applyStimulus(1'b1, 4'd7, 2);
        applyStimulus(1'b0, 4'd7, 1);
        applyStimulus(1'b1, 4'd7, 3);
        checkOutput("t3 no stb at 3rd high", 32'(digit_stb), 32'd0);
        applyStimulus(1'b1, 4'd7, 1);
        checkOutput("t3 stb at 4th high", 32'(digit_stb), 32'd1);
        applyStimulus(1'b1, 4'd7, 3);
        applyStimulus(1'b0, 4'd7, 1);
        applyStimulus(1'b1, 4'd7, 1);
        applyStimulus(1'b0, 4'd7, 2);
        applyStimulus(1'b1, 4'd7, 1);
        applyStimulus(1'b0, 4'd7, 10);
        checkOutput("t3 digits", 32'(digits), 32'h3457);

        // Test 4: code changes 3 -> 8 while counting
        sb.push_back('{16'h4578, 3'd4});
        applyStimulus(1'b1, 4'd3, 2);
        applyStimulus(1'b1, 4'd8, 3);
        checkOutput("t4 no early stb", 32'(digit_stb), 32'd0);
        applyStimulus(1'b1, 4'd8, 1);
        checkOutput("t4 stb", 32'(digit_stb), 32'd1);
        applyStimulus(1'b1, 4'd8, 4);
        applyStimulus(1'b0, 4'd8, 10);
        checkOutput("t4 digits", 32'(digits), 32'h4578);

        // Encoder glitch code never starts a press
        applyStimulus(1'b1, 4'hC, 8);
        checkOutput("glitch busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 4'hC, 4);
        checkOutput("glitch digits", 32'(digits), 32'h4578);

        // Test 5: clear on the accept edge of 9
        applyStimulus(1'b1, 4'd9, 3);
        clear = 1'b1;
        applyStimulus(1'b1, 4'd9, 1);
        clear = 1'b0;
        checkOutput("t5 stb", 32'(digit_stb), 32'd0);
        checkOutput("t5 digits", 32'(digits), 32'h0000);
        checkOutput("t5 count", 32'(digit_count), 32'd0);
        applyStimulus(1'b1, 4'd9, 4);
        applyStimulus(1'b0, 4'd9, 10);
        checkOutput("t5 digits after", 32'(digits), 32'h0000);

        // Test 6: press consumed while disabled, not accepted late
        enable = 1'b0;
        applyStimulus(1'b1, 4'd6, 6);
        checkOutput("t6 disabled digits", 32'(digits), 32'h0000);
        enable = 1'b1;
        applyStimulus(1'b1, 4'd6, 6);
        checkOutput("t6 late enable digits", 32'(digits), 32'h0000);
        checkOutput("t6 late enable count", 32'(digit_count), 32'd0);
        applyStimulus(1'b0, 4'd6, 10);
        sb.push_back('{16'h0006, 3'd1});
        applyStimulus(1'b1, 4'd6, 10);
        applyStimulus(1'b0, 4'd6, 10);
        checkOutput("t6 digits", 32'(digits), 32'h0006);

        checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
